// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared constants for the MEM stage: funct3 access-size encodings,
// the MEM-stage FSM state encoding and the MEM/WB bubble destination.
// No ports; imported by mem_align and mem_stage.
package mem_stage_pkg;

  // Access-size encodings carried on funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // MEM-stage FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Destination register of a squashed / empty writeback slot
  localparam logic [4:0] RD_BUBBLE = 5'd0;

endpackage

// File: rtl/mem_align.sv
// mem_align
// Purely combinational data-path helpers for the MEM stage.
// Ports:
//   funct3, addr_lo, store_data  - access issued from IDLE (current inputs)
//   fault                        - misaligned address or illegal funct3
//   be, wdata                    - byte enables and lane-replicated store data
//   ld_funct3, ld_addr_lo, rdata - latched access plus the returned bus word
//   load_data                    - selected and sign/zero-extended load value
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic        fault,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Fault check: halves need an even address, words a 4-byte aligned one,
  // and the three unused funct3 codes are always rejected.
  always_comb begin
    fault = 1'b0;
    case (funct3)
      F3_B, F3_BU: fault = 1'b0;
      F3_H, F3_HU: fault = addr_lo[0];
      F3_W:        fault = (addr_lo != 2'b00);
      default:     fault = 1'b1;
    endcase
  end

  // Lane steering: the low two funct3 bits give the size for both loads
  // and stores, so the signedness bit does not affect the enables.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Load extraction uses the latched access, since the bus word arrives
  // while the upstream inputs may already be presenting something else.
  always_comb begin
    ld_byte   = rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_half   = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (ld_funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   load_data = {24'd0, ld_byte};
      F3_HU:   load_data = {16'd0, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Pipeline MEM stage: issues data-memory requests, stalls upstream while an
// access is outstanding, and registers the result into MEM/WB.
// All state updates on the falling edge of clk, like the pipeline buffers.
// Ports:
//   clk, rst (async, active-low)
//   MemRead_i, MemtoReg_i, MemWrite_i, ALUResult_i, MemData_i, rd_i,
//   funct3_i                      - from the EX/MEM buffer
//   dmem_req_o/we_o/addr_o/wdata_o/be_o, dmem_rdata_i, dmem_ready_i
//                                 - data-memory request/ready handshake
//   stall_o                       - freezes PC/IF/ID/EX buffers
//   MemtoReg_o, rd_o, ALUResult_o, ReadData_o - MEM/WB register
//   misalign_o, bus_err_o         - one-cycle fault pulses
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_i,
  input  logic        MemtoReg_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] MemData_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i,
  output logic        stall_o,
  output logic        MemtoReg_o,
  output logic [4:0]  rd_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] ReadData_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;
  logic             fault;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;
  logic [31:0]      load_data;

  // Access held across ACCESS/DONE for writeback and load extension
  logic [2:0]       funct3_q;
  logic [31:0]      alu_q;
  logic [4:0]       rd_q;
  logic             memtoreg_q;
  logic [31:0]      rdata_q;
  logic             timed_out_q;

  assign mem_op = MemRead_i | MemWrite_i;

  mem_align u_align (
    .funct3     (funct3_i),
    .addr_lo    (ALUResult_i[1:0]),
    .store_data (MemData_i),
    .fault      (fault),
    .be         (be_next),
    .wdata      (wdata_next),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (alu_q[1:0]),
    .rdata      (dmem_rdata_i),
    .load_data  (load_data)
  );

  // Stall is raised combinationally as soon as an aligned access is seen so
  // the upstream buffers freeze on the same edge the request is latched.
  // Gating with rst keeps it low while reset is asserted.
  always_comb begin
    stall_o = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE:   stall_o = mem_op & ~fault;
        ST_ACCESS: stall_o = 1'b1;
        default:   stall_o = 1'b0;
      endcase
    end
  end

  // FSM, timeout counter, bus request registers and MEM/WB register.
  // A ready arriving on the IDLE edge is ignored because ready is only
  // examined in ACCESS, i.e. from the edge after the request rises.
  // When MemRead and MemWrite are both set the access is a load.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      MemtoReg_o   <= 1'b0;
      rd_o         <= RD_BUBBLE;
      ALUResult_o  <= '0;
      ReadData_o   <= '0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
      funct3_q     <= '0;
      alu_q        <= '0;
      rd_q         <= RD_BUBBLE;
      memtoreg_q   <= 1'b0;
      rdata_q      <= '0;
      timed_out_q  <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!mem_op) begin
            MemtoReg_o  <= MemtoReg_i;
            rd_o        <= rd_i;
            ALUResult_o <= ALUResult_i;
            ReadData_o  <= '0;
          end else begin
            MemtoReg_o  <= 1'b0;
            rd_o        <= RD_BUBBLE;
            ALUResult_o <= '0;
            ReadData_o  <= '0;
            if (fault) begin
              misalign_o <= 1'b1;
            end else begin
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= MemWrite_i & ~MemRead_i;
              dmem_addr_o  <= {ALUResult_i[31:2], 2'b00};
              dmem_wdata_o <= wdata_next;
              dmem_be_o    <= be_next;
              funct3_q     <= funct3_i;
              alu_q        <= ALUResult_i;
              rd_q         <= rd_i;
              memtoreg_q   <= MemtoReg_i;
              rdata_q      <= '0;
              timed_out_q  <= 1'b0;
              cnt          <= '0;
              state        <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (dmem_ready_i) begin
            if (!dmem_we_o) begin
              rdata_q <= load_data;
            end
            dmem_req_o <= 1'b0;
            state      <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            dmem_req_o  <= 1'b0;
            bus_err_o   <= 1'b1;
            timed_out_q <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (timed_out_q) begin
            MemtoReg_o  <= 1'b0;
            rd_o        <= RD_BUBBLE;
            ALUResult_o <= '0;
            ReadData_o  <= '0;
          end else begin
            MemtoReg_o  <= memtoreg_q;
            rd_o        <= rd_q;
            ALUResult_o <= alu_q;
            ReadData_o  <= rdata_q;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Randomised scoreboard bench for mem_stage. A driver issues instructions
// and holds them while stall_o is high, a memory responder answers requests
// after a chosen latency, and a monitor checks every MEM/WB update.
module tb_mem_stage;

  localparam int T = 16;

  logic        clk;
  logic        rst;
  logic        MemRead_i, MemtoReg_i, MemWrite_i;
  logic [31:0] ALUResult_i, MemData_i;
  logic [4:0]  rd_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ready_i;
  logic        stall_o, MemtoReg_o;
  logic [4:0]  rd_o;
  logic [31:0] ALUResult_o, ReadData_o;
  logic        misalign_o, bus_err_o;

  typedef struct {
    logic        bubble;
    logic [4:0]  rd;
    logic        mtr;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        chk_rdata;
    int          mis;
    int          berr;
    int          stalls;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } req_t;

  wb_t  exp_q[$];
  req_t req_q[$];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 0;

  mem_stage #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead_i    (MemRead_i),
    .MemtoReg_i   (MemtoReg_i),
    .MemWrite_i   (MemWrite_i),
    .ALUResult_i  (ALUResult_i),
    .MemData_i    (MemData_i),
    .rd_i         (rd_i),
    .funct3_i     (funct3_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_rdata_i (dmem_rdata_i),
    .dmem_ready_i (dmem_ready_i),
    .stall_o      (stall_o),
    .MemtoReg_o   (MemtoReg_o),
    .rd_o         (rd_o),
    .ALUResult_o  (ALUResult_o),
    .ReadData_o   (ReadData_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  // The DUT is negedge-active; the bench samples on posedge and drives
  // one time unit after it.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: derives the expected bus request and writeback from
  // access size, offset and latency, then issues the instruction and holds
  // it until an edge occurs with stall_o low.
  task automatic applyStimulus(input logic mr, input logic mw, input logic mtr,
                               input logic [31:0] alu, input logic [31:0] data,
                               input logic [4:0] rd, input logic [2:0] f3,
                               input int lat, input logic [31:0] rdata);
    int     sz, off, guard;
    bit     memop, fault, tout, s;
    longint span, v;
    wb_t    e;
    req_t   r;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    off   = int'(alu[1:0]);
    memop = mr | mw;
    fault = memop && (sz == 0 || (off % sz) != 0);
    tout  = lat >= T;
    e = '{bubble: 1'b0, rd: rd, mtr: mtr, alu: alu, rdata: 32'd0,
          chk_rdata: 1'b1, mis: 0, berr: 0, stalls: 0};
    if (memop && fault) begin
      e.bubble = 1'b1; e.rd = 5'd0; e.mtr = 1'b0; e.mis = 1;
    end else if (memop) begin
      r.addr  = alu & 32'hFFFF_FFFC;
      r.we    = mw & ~mr;
      r.be    = 4'(((1 << sz) - 1) << off);
      if (sz == 1)      r.wdata = (data & 32'hFF) * 32'h0101_0101;
      else if (sz == 2) r.wdata = (data & 32'hFFFF) * 32'h0001_0001;
      else              r.wdata = data;
      r.lat   = lat;
      r.rdata = rdata;
      req_q.push_back(r);
      if (tout) begin
        e.bubble = 1'b1; e.rd = 5'd0; e.mtr = 1'b0; e.berr = 1; e.stalls = 1 + T;
      end else begin
        e.stalls    = lat + 2;
        e.chk_rdata = mr;
        if (mr) begin
          span = longint'(1) << (8 * sz);
          v    = (longint'(rdata) >> (8 * off)) % span;
          if (f3 < 3'd4 && sz < 4 && v >= span / 2) v = v - span;
          e.rdata = 32'(v);
        end
      end
    end
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    MemRead_i = mr; MemWrite_i = mw; MemtoReg_i = mtr;
    ALUResult_i = alu; MemData_i = data; rd_i = rd; funct3_i = f3;
    mon_en = 1'b1;
    guard = 0;
    forever begin
      #3;
      s = stall_o;
      @(negedge clk);
      if (!s) break;
      guard++;
      if (guard > 100) begin
        vectors++; miscompares++;
        $display("[TB] FAIL stall_release: got stall for %0d cycles, expected at most 100", guard);
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: each posedge shows the result of the previous falling edge.
  // Edges taken with stall high must leave a bubble; the edge taken with
  // stall low retires the oldest instruction in the scoreboard.
  initial begin
    bit  have_prev, prev_stall;
    int  stall_cnt, mis_cnt, berr_cnt;
    wb_t e;
    have_prev = 0; prev_stall = 0;
    stall_cnt = 0; mis_cnt = 0; berr_cnt = 0;
    forever begin
      @(posedge clk);
      if (have_prev) begin
        if (misalign_o) mis_cnt++;
        if (bus_err_o) berr_cnt++;
        if (prev_stall) begin
          stall_cnt++;
          checkOutput("bubble_rd", {27'd0, rd_o}, 32'd0);
        end else if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("[TB] FAIL unexpected_retire: got rd_o=%0d, expected no writeback", rd_o);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wb_rd", {27'd0, rd_o}, {27'd0, e.rd});
          checkOutput("wb_memtoreg", {31'd0, MemtoReg_o}, {31'd0, e.mtr});
          if (!e.bubble) checkOutput("wb_alu", ALUResult_o, e.alu);
          if (!e.bubble && e.chk_rdata) checkOutput("wb_readdata", ReadData_o, e.rdata);
          checkOutput("misalign_pulses", mis_cnt, e.mis);
          checkOutput("bus_err_pulses", berr_cnt, e.berr);
          checkOutput("stall_cycles", stall_cnt, e.stalls);
          stall_cnt = 0; mis_cnt = 0; berr_cnt = 0;
        end
      end
      #4;
      prev_stall = stall_o;
      have_prev  = mon_en;
    end
  end

  // Memory responder: checks the request fields while a request is up and
  // raises ready after the chosen number of wait cycles; when idle it drives
  // random ready/rdata so a stray ready on the issue edge is exercised.
  initial begin
    bit   busy;
    int   waited;
    req_t cur;
    busy = 0; waited = 0;
    cur  = '{addr: 32'd0, we: 1'b0, be: 4'd0, wdata: 32'd0, lat: 1 << 30, rdata: 32'd0};
    dmem_ready_i = 1'b0;
    dmem_rdata_i = 32'd0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        busy = 0;
        dmem_ready_i = 1'b0;
      end else if (dmem_req_o) begin
        if (!busy) begin
          busy = 1; waited = 0;
          if (req_q.size() == 0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL unexpected_req: got request to 0x%0h, expected none", dmem_addr_o);
            cur = '{addr: dmem_addr_o, we: dmem_we_o, be: dmem_be_o, wdata: dmem_wdata_o,
                    lat: 1 << 30, rdata: 32'd0};
          end else begin
            cur = req_q.pop_front();
          end
        end
        checkOutput("req_addr", dmem_addr_o, cur.addr);
        checkOutput("req_we", {31'd0, dmem_we_o}, {31'd0, cur.we});
        checkOutput("req_be", {28'd0, dmem_be_o}, {28'd0, cur.be});
        if (cur.we) checkOutput("req_wdata", dmem_wdata_o, cur.wdata);
        if (waited >= cur.lat) begin
          dmem_ready_i = 1'b1;
          dmem_rdata_i = cur.rdata;
        end else begin
          dmem_ready_i = 1'b0;
          dmem_rdata_i = $urandom;
          waited++;
        end
      end else begin
        busy = 0;
        dmem_ready_i = 1'($urandom_range(0, 1));
        dmem_rdata_i = $urandom;
      end
    end
  end

  initial begin
    logic        mr, mw, mtr;
    logic [31:0] alu, data, rdata;
    logic [4:0]  rd;
    logic [2:0]  f3;
    int          lat, kind, r;
    logic [2:0]  ld_codes [5];
    logic [2:0]  bad_codes [3];
    ld_codes  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bad_codes = '{3'd3, 3'd6, 3'd7};

    rst = 1'b0;
    MemRead_i = 0; MemWrite_i = 0; MemtoReg_i = 0;
    ALUResult_i = 0; MemData_i = 0; rd_i = 0; funct3_i = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req", {31'd0, dmem_req_o}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("reset_rd", {27'd0, rd_o}, 32'd0);
    checkOutput("reset_alu", ALUResult_o, 32'd0);
    checkOutput("reset_readdata", ReadData_o, 32'd0);
    checkOutput("reset_be", {28'd0, dmem_be_o}, 32'd0);
    checkOutput("reset_misalign", {31'd0, misalign_o}, 32'd0);
    checkOutput("reset_bus_err", {31'd0, bus_err_o}, 32'd0);
    rst = 1'b1;

    // Reset while an access is outstanding
    @(posedge clk);
    #1;
    MemRead_i = 1; funct3_i = 3'd2; ALUResult_i = 32'h200; rd_i = 5'd4;
    req_q.push_back('{addr: 32'h200, we: 1'b0, be: 4'hF, wdata: 32'd0, lat: 1 << 30, rdata: 32'd0});
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("access_req", {31'd0, dmem_req_o}, 32'd1);
    checkOutput("access_stall", {31'd0, stall_o}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset_req", {31'd0, dmem_req_o}, 32'd0);
    checkOutput("midreset_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("midreset_rd", {27'd0, rd_o}, 32'd0);
    MemRead_i = 0; funct3_i = 0; ALUResult_i = 0; rd_i = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("after_reset_stall", {31'd0, stall_o}, 32'd0);

    // Directed cases
    applyStimulus(0, 0, 0, 32'h1234, 32'd0, 5'd5, 3'd0, 0, 32'd0);
    applyStimulus(1, 0, 1, 32'h103, 32'd0, 5'd7, 3'd0, 2, 32'h80FF_FF00);
    applyStimulus(0, 1, 0, 32'h202, 32'hABCD_5678, 5'd0, 3'd1, 0, 32'd0);
    applyStimulus(1, 0, 1, 32'h101, 32'd0, 5'd9, 3'd2, 0, 32'd0);
    applyStimulus(1, 0, 1, 32'h40, 32'd0, 5'd3, 3'd5, 1000, 32'd0);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      mtr  = 1'($urandom_range(0, 1));
      rd   = 5'($urandom);
      alu  = $urandom;
      data = $urandom;
      rdata = $urandom;
      mr = 0; mw = 0; f3 = 3'($urandom);
      if (kind >= 3 && kind <= 6) begin
        mr = 1; mw = 1'($urandom_range(0, 3) == 0);
        f3 = ld_codes[$urandom_range(0, 4)];
      end else if (kind >= 7) begin
        mw = 1;
        f3 = 3'($urandom_range(0, 2));
      end
      if ((mr | mw) && $urandom_range(0, 7) == 0) f3 = bad_codes[$urandom_range(0, 2)];
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) alu[0] = 1'b0;
        if (f3 == 3'd2) alu[1:0] = 2'b00;
      end
      r = $urandom_range(0, 9);
      if (r < 7)       lat = $urandom_range(0, 3);
      else if (r == 7) lat = T - 1;
      else if (r == 8) lat = T;
      else             lat = 40;
      applyStimulus(mr, mw, mtr, alu, data, rd, f3, lat, rdata);
    end

    applyStimulus(0, 0, 0, 32'h0, 32'd0, 5'd0, 3'd0, 0, 32'd0);
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    checkOutput("req_queue_empty", req_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage. Sits directly downstream of the EX/MEM buffer and consumes its MemRead/MemtoReg/MemWrite/ALUResult/MemData/rd outputs, plus funct3.
- Drives a data-memory request/ready handshake and performs byte/half/word alignment and load extension.
- Stalls the pipeline while an access is outstanding.
- Registers the result into the MEM/WB boundary for writeback.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in ACCESS waiting for dmem_ready_i before abort (≥1)
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock; all state and output registers update on negedge clk, the same edge as the pipeline buffers
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
MemRead_i  in  1  load request from EX/MEM buffer
MemtoReg_i  in  1  writeback selects memory data
MemWrite_i  in  1  store request
ALUResult_i  in  32  effective address / ALU result
MemData_i  in  32  store data (rs2)
rd_i  in  5  destination register
funct3_i  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
dmem_req_o  out  1  bus request, held until accepted
dmem_we_o  out  1  1=store
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata_o  out  32  lane-replicated store data
dmem_be_o  out  4  byte enables
dmem_rdata_i  in  32  read word
dmem_ready_i  in  1  access complete, sampled on negedge
stall_o  out  1  freeze PC/IF/ID/EX buffers
MemtoReg_o  out  1  MEM/WB register
rd_o  out  5  MEM/WB register; 0 = bubble
ALUResult_o  out  32  MEM/WB register
ReadData_o  out  32  extended load data
misalign_o  out  1  one-cycle pulse: misaligned or illegal funct3 access squashed
bus_err_o  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0.
  - All outputs 0, including dmem_req_o. stall_o=0.
  - Reset mid-ACCESS drops dmem_req_o immediately.
- mem_op = MemRead_i | MemWrite_i. If both are set, treat as load.
- Alignment fault when any of:
  - funct3 ∈ {011,110,111};
  - H/HU/SH with addr[0]=1;
  - W/SW with addr[1:0]≠0.
- FSM IDLE:
  - No mem_op: stall_o=0. Each edge loads MEM/WB with MemtoReg_i, rd_i, ALUResult_i; ReadData_o=0. Latency 1 edge.
  - mem_op with fault: stall_o=0. Edge loads a bubble (rd_o=0, MemtoReg_o=0) and pulses misalign_o. No bus access.
  - mem_op, aligned: stall_o=1 combinationally. Edge latches address, we, be, wdata, funct3, rd, MemtoReg; loads a MEM/WB bubble; goes to ACCESS; sets dmem_req_o=1; clears counter.
- FSM ACCESS:
  - stall_o=1, dmem_req_o=1, request fields stable.
  - dmem_ready_i=1 at edge: capture extended rdata (loads), drop req, go to DONE. A ready seen on the same edge the request first asserts is not accepted.
  - Else counter++. On reaching TIMEOUT_CYCLES: drop req, pulse bus_err_o, load bubble, go to DONE.
  - MEM/WB holds a bubble throughout.
- FSM DONE:
  - stall_o=0.
  - Edge loads MEM/WB with the latched rd/MemtoReg/ALUResult and the captured ReadData. After a timeout, a bubble is loaded instead.
  - Next state IDLE. Upstream advances on this same edge, so the next instruction is seen in IDLE.
- Store lanes:
  - SB: wdata={4{d[7:0]}}, be=0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, be=addr[1]?1100:0011.
  - SW: wdata=d, be=1111.
  - For loads, be uses the same encoding and we=0.
- Load extend: pick the byte via addr[1:0] or the half via addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Back-to-back mem ops each take IDLE→ACCESS→DONE, so minimum 3 edges per access with zero-wait memory.

Decomposition:
- Shared package holds:
  - funct3 size encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state encoding (ST_IDLE, ST_ACCESS, ST_DONE, 2 bits);
  - bubble constant rd=5'd0.
- One natural sub-module, mem_align: combinational fault detection, be/wdata generation, and load extension.
- FSM, counter and MEM/WB register stay in mem_stage.

Test Plan:
- Reset mid-ACCESS: rst=0 → dmem_req_o, stall_o, rd_o all 0 immediately; then IDLE.
- Non-mem ALU op (rd=5, ALUResult=0x1234): after 1 negedge → rd_o=5, ALUResult_o=0x1234, stall_o=0 throughout.
- LB at addr 0x103, rdata=0x80FF_FF00, ready after 2 wait cycles:
  - stall_o=1 for IDLE+ACCESS;
  - be=1000, dmem_addr_o=0x100;
  - in DONE, ReadData_o=0xFFFF_FF80 and rd_o set.
- SH data 0xABCD_5678 at 0x202, ready immediately:
  - wdata=0x5678_5678, be=1100, we=1;
  - rd_o stays 0 (store rd=0);
  - 3 edges total.
- LW at 0x101: no dmem_req_o, misalign_o one pulse, rd_o=0, stall_o=0.
- LHU at 0x40 with dmem_ready_i never asserted (TIMEOUT_CYCLES=16): bus_err_o pulses after 16 ACCESS edges, req drops, rd_o=0, FSM returns to IDLE.
